// File: rtl/jtdd_adpcm_seq.sv
// ADPCM nibble sequencer: per-channel ROM pointers and one-byte buffers, fed by a
// round-robin fetch engine on a shared ROM port and drained one nibble per sample strobe.
module jtdd_adpcm_seq #(
    parameter  int CH  = 2,
    parameter  int AW  = 16,
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cpu_cen,
    input  logic              cen_oki,
    input  logic              cs,
    input  logic [CHW-1:0]    cpu_ch,
    input  logic [1:0]        cpu_reg,
    input  logic [7:0]        cpu_dout,
    output logic [CHW+AW-1:0] rom_addr,
    output logic              rom_cs,
    input  logic [7:0]        rom_data,
    input  logic              rom_ok,
    output logic [4*CH-1:0]   nib,
    output logic [CH-1:0]     nib_stb,
    output logic [CH-1:0]     busy,
    output logic [CH-1:0]     underrun
);

    localparam int PW = AW - 8;

    typedef enum logic [1:0] {IDLE, SETTLE, READ} state_t;

    state_t              state_q;
    logic [CHW-1:0]      gnt_q;
    logic [CHW-1:0]      rr_q;
    logic                discard_q;
    logic [CHW+AW-1:0]   romAddr_q;
    logic                romCs_q;

    logic [AW-1:0]       ptr_q     [CH];
    logic [PW-1:0]       startPg_q [CH];
    logic [PW-1:0]       endPg_q   [CH];
    logic [7:0]          data_q    [CH];
    logic [CH-1:0]       valid_q;
    logic [CH-1:0]       half_q;
    logic [CH-1:0]       busy_q;
    logic [CH-1:0]       underrun_q;
    logic [CH-1:0]       nibStb_q;
    logic [4*CH-1:0]     nib_q;

    logic [CHW-1:0]      gnt_d;
    logic                anyReq;
    logic [CHW-1:0]      scanIdx;
    logic [31:0]         chExt;
    logic                wrEn;
    logic [CH-1:0]       wrHit;
    logic [CH-1:0]       ctlHit;
    logic [CH-1:0]       req;
    logic [CH-1:0]       fill;
    logic                unused_dout;

    assign unused_dout = &{1'b0, cpu_dout};

    // ctlHit marks start/stop writes; they cancel any fetch in flight for that channel
    always_comb begin
        chExt  = 32'(cpu_ch);
        wrEn   = cs & cpu_cen & (chExt < 32'(CH));
        wrHit  = '0;
        ctlHit = '0;
        req    = '0;
        fill   = '0;
        for (int c = 0; c < CH; c++) begin
            wrHit[c]  = wrEn && (cpu_ch == CHW'(c));
            ctlHit[c] = wrHit[c] & cpu_reg[1];
            req[c]    = busy_q[c] & ~valid_q[c] &
                        ~((state_q != IDLE) && (gnt_q == CHW'(c)));
            fill[c]   = (state_q == READ) & rom_ok & (gnt_q == CHW'(c)) &
                        ~discard_q & ~ctlHit[c];
        end
    end

    // Scan from rr_q upwards; iterating backwards lets the closest requester win
    always_comb begin
        gnt_d   = '0;
        anyReq  = 1'b0;
        scanIdx = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            scanIdx = CHW'((int'(rr_q) + i) % CH);
            if (req[scanIdx]) begin
                anyReq = 1'b1;
                gnt_d  = scanIdx;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            rr_q      <= '0;
            discard_q <= 1'b0;
            romAddr_q <= '0;
            romCs_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (anyReq) begin
                        gnt_q     <= gnt_d;
                        rr_q      <= CHW'((int'(gnt_d) + 1) % CH);
                        romAddr_q <= {gnt_d, ptr_q[gnt_d]};
                        romCs_q   <= 1'b1;
                        discard_q <= ctlHit[gnt_d];
                        state_q   <= SETTLE;
                    end
                end
                SETTLE: begin
                    discard_q <= discard_q | ctlHit[gnt_q];
                    state_q   <= READ;
                end
                READ: begin
                    discard_q <= discard_q | ctlHit[gnt_q];
                    if (rom_ok) begin
                        romCs_q   <= 1'b0;
                        discard_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A register write to a channel takes priority over its sample strobe
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < CH; c++) begin
                ptr_q[c]     <= '0;
                startPg_q[c] <= '0;
                endPg_q[c]   <= '0;
                data_q[c]    <= '0;
            end
            valid_q    <= '0;
            half_q     <= '0;
            busy_q     <= '0;
            underrun_q <= '0;
            nibStb_q   <= '0;
            nib_q      <= '0;
        end else begin
            nibStb_q <= '0;
            for (int c = 0; c < CH; c++) begin
                if (fill[c]) begin
                    data_q[c]  <= rom_data;
                    valid_q[c] <= 1'b1;
                end
                if (wrHit[c]) begin
                    case (cpu_reg)
                        2'd0: startPg_q[c] <= cpu_dout[PW-1:0];
                        2'd1: endPg_q[c]   <= cpu_dout[PW-1:0];
                        2'd2: begin
                            ptr_q[c]      <= {startPg_q[c], 8'h00};
                            busy_q[c]     <= 1'b1;
                            underrun_q[c] <= 1'b0;
                            valid_q[c]    <= 1'b0;
                            half_q[c]     <= 1'b0;
                        end
                        default: begin
                            busy_q[c]  <= 1'b0;
                            valid_q[c] <= 1'b0;
                        end
                    endcase
                end else if (cen_oki && busy_q[c]) begin
                    if (valid_q[c]) begin
                        nibStb_q[c]      <= 1'b1;
                        half_q[c]        <= ~half_q[c];
                        nib_q[4*c +: 4]  <= half_q[c] ? data_q[c][3:0] : data_q[c][7:4];
                        if (half_q[c]) begin
                            valid_q[c] <= 1'b0;
                            if (ptr_q[c] == {endPg_q[c], 8'hFF}) begin
                                busy_q[c] <= 1'b0;
                            end else begin
                                ptr_q[c] <= ptr_q[c] + 1'b1;
                            end
                        end
                    end else begin
                        underrun_q[c] <= 1'b1;
                    end
                end
            end
        end
    end

    assign rom_addr = romAddr_q;
    assign rom_cs   = romCs_q;
    assign nib      = nib_q;
    assign nib_stb  = nibStb_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_jtdd_adpcm_seq.sv
// Directed bench for jtdd_adpcm_seq: ROM model returns addr[7:0]^romXor with rom_ok two
// clocks after rom_cs; a monitor logs grants and nibble strobes for the checks.
module tb_jtdd_adpcm_seq;

    localparam int CH  = 2;
    localparam int AW  = 16;
    localparam int CHW = 1;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              cpu_cen = 1'b0;
    logic              cen_oki = 1'b0;
    logic              cs = 1'b0;
    logic [CHW-1:0]    cpu_ch = '0;
    logic [1:0]        cpu_reg = '0;
    logic [7:0]        cpu_dout = '0;
    logic [CHW+AW-1:0] rom_addr;
    logic              rom_cs;
    logic [7:0]        rom_data;
    logic              rom_ok;
    logic [4*CH-1:0]   nib;
    logic [CH-1:0]     nib_stb;
    logic [CH-1:0]     busy;
    logic [CH-1:0]     underrun;

    int checks = 0;
    int failures = 0;

    int          romCnt = 0;
    logic        romEnable = 1'b1;
    logic [7:0]  romXor = 8'h00;

    logic [16:0] grantQ [$];
    int          stbCh  [$];
    logic [3:0]  stbNib [$];
    int          instab = 0;
    logic        prevCs = 1'b0;
    logic [16:0] curGrant = '0;

    jtdd_adpcm_seq #(.CH(CH), .AW(AW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cpu_cen  (cpu_cen),
        .cen_oki  (cen_oki),
        .cs       (cs),
        .cpu_ch   (cpu_ch),
        .cpu_reg  (cpu_reg),
        .cpu_dout (cpu_dout),
        .rom_addr (rom_addr),
        .rom_cs   (rom_cs),
        .rom_data (rom_data),
        .rom_ok   (rom_ok),
        .nib      (nib),
        .nib_stb  (nib_stb),
        .busy     (busy),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rstn) begin
        if (!rstn)        romCnt <= 0;
        else if (!rom_cs) romCnt <= 0;
        else              romCnt <= romCnt + 1;
    end

    assign rom_ok   = romEnable && rom_cs && (romCnt >= 2);
    assign rom_data = rom_addr[7:0] ^ romXor;

    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (nib_stb[c]) begin
                stbCh.push_back(c);
                stbNib.push_back(nib[4*c +: 4]);
            end
        end
        if (rom_cs && !prevCs) begin
            grantQ.push_back(rom_addr);
            curGrant = rom_addr;
        end else if (rom_cs && (rom_addr !== curGrant)) begin
            instab++;
        end
        prevCs = rom_cs;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [CHW-1:0] ch, input logic [1:0] r,
                                 input logic [7:0] d, input logic cen);
        cs = 1'b1; cpu_cen = cen; cpu_ch = ch; cpu_reg = r; cpu_dout = d;
        @(negedge clk);
        cs = 1'b0; cpu_cen = 1'b0;
    endtask

    task automatic pulseOki(input int gap);
        cen_oki = 1'b1;
        @(negedge clk);
        cen_oki = 1'b0;
        tick(gap - 1);
    endtask

    task automatic clearMon();
        grantQ.delete();
        stbCh.delete();
        stbNib.delete();
        instab = 0;
    endtask

    function automatic logic [3:0] expNib(input int n, input logic [7:0] x);
        logic [7:0] b;
        b = 8'(n >> 1) ^ x;
        return (n % 2 == 1) ? b[3:0] : b[7:4];
    endfunction

    function automatic int countCh(input int ch);
        int k = 0;
        foreach (stbCh[i]) if (stbCh[i] == ch) k++;
        return k;
    endfunction

    initial begin
        int errs;
        int n;
        int w;

        // Reset values
        tick(3);
        checkOutput("rst_rom_cs", rom_cs, 0);
        checkOutput("rst_rom_addr", rom_addr, 0);
        checkOutput("rst_nib", nib, 0);
        checkOutput("rst_nib_stb", nib_stb, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_underrun", underrun, 0);
        rstn = 1'b1;
        tick(2);

        // Single page playback on ch0
        clearMon();
        applyStimulus(0, 2'd0, 8'h12, 1'b1);
        applyStimulus(0, 2'd1, 8'h12, 1'b1);
        applyStimulus(0, 2'd2, 8'h00, 1'b1);
        tick(12);
        for (int i = 0; i < 512; i++) begin
            pulseOki(8);
            if (i == 510) checkOutput("p1_busy_before_last", busy[0], 1);
        end
        checkOutput("p1_stb_count", stbNib.size(), 512);
        checkOutput("p1_first_nib", stbNib[0], 0);
        checkOutput("p1_second_nib", stbNib[1], 0);
        checkOutput("p1_last_nib_hi", stbNib[510], 4'hF);
        checkOutput("p1_last_nib_lo", stbNib[511], 4'hF);
        errs = 0;
        foreach (stbNib[i]) if (stbNib[i] !== expNib(i, 8'h00) || stbCh[i] != 0) errs++;
        checkOutput("p1_nib_seq_errs", errs, 0);
        checkOutput("p1_grant_count", grantQ.size(), 256);
        checkOutput("p1_first_grant", grantQ[0], 17'h01200);
        checkOutput("p1_last_grant", grantQ[255], 17'h012FF);
        errs = 0;
        foreach (grantQ[i]) if (grantQ[i] !== 17'(17'h01200 + i)) errs++;
        checkOutput("p1_grant_seq_errs", errs, 0);
        checkOutput("p1_busy_end", busy[0], 0);
        checkOutput("p1_underrun", underrun[0], 0);
        checkOutput("p1_addr_stable", instab, 0);
        pulseOki(8);
        checkOutput("p1_idle_strobe", stbNib.size(), 512);

        // Two channels alternate grants
        clearMon();
        applyStimulus(0, 2'd0, 8'h20, 1'b1);
        applyStimulus(0, 2'd1, 8'h20, 1'b1);
        applyStimulus(1, 2'd0, 8'h30, 1'b1);
        applyStimulus(1, 2'd1, 8'h30, 1'b1);
        applyStimulus(0, 2'd2, 8'h00, 1'b1);
        applyStimulus(1, 2'd2, 8'h00, 1'b1);
        tick(12);
        for (int i = 0; i < 8; i++) pulseOki(12);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("p2_grant%0d", k), grantQ[k],
                        (k % 2 == 0) ? 32'(17'h02000 + k / 2) : 32'(17'h13000 + k / 2));
        end
        checkOutput("p2_ch0_stb", countCh(0), 8);
        checkOutput("p2_ch1_stb", countCh(1), 8);
        errs = 0;
        n = 0;
        foreach (stbNib[i]) begin
            if (stbCh[i] == 1) begin
                if (stbNib[i] !== expNib(n, 8'h00)) errs++;
                n++;
            end
        end
        checkOutput("p2_ch1_nib_errs", errs, 0);
        checkOutput("p2_underrun", underrun, 0);
        applyStimulus(0, 2'd3, 8'h00, 1'b1);
        applyStimulus(1, 2'd3, 8'h00, 1'b1);
        tick(10);
        checkOutput("p2_busy_stopped", busy, 0);
        checkOutput("p2_rom_cs_idle", rom_cs, 0);

        // Underrun while ROM stalls, then resume
        clearMon();
        romEnable = 1'b0;
        romXor = 8'hA5;
        applyStimulus(0, 2'd0, 8'h40, 1'b1);
        applyStimulus(0, 2'd1, 8'h40, 1'b1);
        applyStimulus(0, 2'd2, 8'h00, 1'b1);
        tick(4);
        for (int i = 0; i < 10; i++) pulseOki(8);
        checkOutput("p3_underrun", underrun[0], 1);
        checkOutput("p3_no_stb", stbNib.size(), 0);
        checkOutput("p3_rom_cs_stalled", rom_cs, 1);
        checkOutput("p3_busy", busy[0], 1);
        romEnable = 1'b1;
        tick(6);
        for (int i = 0; i < 4; i++) pulseOki(8);
        checkOutput("p3_stb_count", stbNib.size(), 4);
        checkOutput("p3_nib0", stbNib[0], 4'hA);
        checkOutput("p3_nib1", stbNib[1], 4'h5);
        checkOutput("p3_nib2", stbNib[2], 4'hA);
        checkOutput("p3_nib3", stbNib[3], 4'h4);
        checkOutput("p3_grant0", grantQ[0], 17'h04000);
        checkOutput("p3_grant1", grantQ[1], 17'h04001);
        checkOutput("p3_underrun_sticky", underrun[0], 1);
        applyStimulus(0, 2'd3, 8'h00, 1'b1);
        tick(10);
        romXor = 8'h00;

        // Pointer wrap from 0xFFFF to 0x0000 on ch1
        clearMon();
        applyStimulus(1, 2'd0, 8'hFF, 1'b1);
        applyStimulus(1, 2'd1, 8'h00, 1'b1);
        applyStimulus(1, 2'd2, 8'h00, 1'b1);
        tick(12);
        for (int i = 0; i < 1024; i++) pulseOki(8);
        checkOutput("p4_grant_count", grantQ.size(), 512);
        checkOutput("p4_grant_first", grantQ[0], 17'h1FF00);
        checkOutput("p4_grant_top", grantQ[255], 17'h1FFFF);
        checkOutput("p4_grant_wrap", grantQ[256], 17'h10000);
        checkOutput("p4_grant_last", grantQ[511], 17'h100FF);
        checkOutput("p4_stb_count", stbNib.size(), 1024);
        errs = 0;
        foreach (stbNib[i]) if (stbNib[i] !== expNib(i, 8'h00) || stbCh[i] != 1) errs++;
        checkOutput("p4_nib_seq_errs", errs, 0);
        checkOutput("p4_busy_end", busy[1], 0);
        checkOutput("p4_addr_stable", instab, 0);

        // Gated write, then stop during READ
        clearMon();
        applyStimulus(0, 2'd2, 8'h00, 1'b0);
        tick(3);
        checkOutput("p5_gated_busy", busy[0], 0);
        checkOutput("p5_gated_underrun", underrun[0], 1);
        checkOutput("p5_gated_rom_cs", rom_cs, 0);
        romEnable = 1'b0;
        applyStimulus(0, 2'd0, 8'h50, 1'b1);
        applyStimulus(0, 2'd1, 8'h50, 1'b1);
        applyStimulus(0, 2'd2, 8'h00, 1'b1);
        tick(5);
        checkOutput("p5_in_read", rom_cs, 1);
        applyStimulus(0, 2'd3, 8'h00, 1'b1);
        checkOutput("p5_stop_busy", busy[0], 0);
        checkOutput("p5_cs_held", rom_cs, 1);
        romEnable = 1'b1;
        tick(3);
        checkOutput("p5_cs_dropped", rom_cs, 0);
        for (int i = 0; i < 4; i++) pulseOki(8);
        checkOutput("p5_no_stb", stbNib.size(), 0);
        checkOutput("p5_single_grant", grantQ.size(), 1);
        checkOutput("p5_underrun", underrun[0], 0);

        // Asynchronous reset in the middle of a fetch
        romEnable = 1'b0;
        applyStimulus(0, 2'd0, 8'h60, 1'b1);
        applyStimulus(0, 2'd1, 8'h60, 1'b1);
        applyStimulus(0, 2'd2, 8'h00, 1'b1);
        w = 0;
        while (!rom_cs && w < 20) begin
            tick(1);
            w++;
        end
        checkOutput("p6_fetch_seen", rom_cs, 1);
        #2 rstn = 1'b0;
        #1;
        checkOutput("p6_rst_rom_cs", rom_cs, 0);
        checkOutput("p6_rst_rom_addr", rom_addr, 0);
        checkOutput("p6_rst_busy", busy, 0);
        checkOutput("p6_rst_nib", nib, 0);
        checkOutput("p6_rst_nib_stb", nib_stb, 0);
        checkOutput("p6_rst_underrun", underrun, 0);
        @(negedge clk);
        rstn = 1'b1;
        romEnable = 1'b1;
        tick(2);
        clearMon();
        applyStimulus(0, 2'd0, 8'h70, 1'b1);
        applyStimulus(0, 2'd1, 8'h70, 1'b1);
        applyStimulus(0, 2'd2, 8'h00, 1'b1);
        tick(12);
        pulseOki(8);
        pulseOki(8);
        checkOutput("p6_fresh_grant", grantQ[0], 17'h07000);
        checkOutput("p6_stb_count", stbNib.size(), 2);
        checkOutput("p6_busy", busy[0], 1);
        applyStimulus(0, 2'd3, 8'h00, 1'b1);
        tick(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtdd_adpcm_seq.md
JTDD_ADPCM_SEQ -- requirements
Module: jtdd_adpcm_seq

Interface
REQ-001 Parameter CH, default 2: number of ADPCM channels (1..8); CHW = max(1, clog2(CH)).
REQ-002 Parameter AW, default 16: per-channel ROM byte-address width (9..16).
REQ-003 clk  input  1  system clock, 24 MHz.
REQ-004 rstn  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 cpu_cen  input  1  CPU bus strobe; register writes are sampled only when high.
REQ-006 cen_oki  input  1  sample strobe, one-clk pulse, 375 kHz nominal.
REQ-007 cs  input  1  register write select, active high.
REQ-008 cpu_ch  input  CHW  target channel of the write.
REQ-009 cpu_reg  input  2  register index.
REQ-010 cpu_dout  input  8  CPU write data.
REQ-011 rom_addr  output  CHW+AW  shared ROM address = {channel, pointer}.
REQ-012 rom_cs  output  1  ROM request.
REQ-013 rom_data  input  8  ROM byte.
REQ-014 rom_ok  input  1  ROM data valid.
REQ-015 nib  output  4*CH  current nibble per channel, channel n at bits [4n+3:4n].
REQ-016 nib_stb  output  CH  one-clk pulse per channel when its nib updates.
REQ-017 busy  output  CH  channel playing.
REQ-018 underrun  output  CH  sticky: strobe arrived with channel buffer empty.

Function
REQ-019 Writes act only when cs & cpu_cen; cpu_ch >= CH is ignored.
REQ-020 reg0: start page := cpu_dout[AW-9:0]; start address = {page, 8'h00}.
REQ-021 reg1: end page := cpu_dout[AW-9:0]; end address = {page, 8'hFF}, inclusive.
REQ-022 reg2: start; ptr := start address, busy := 1, underrun := 0, buffer invalidated.
REQ-023 reg3: stop; busy := 0, buffer invalidated; nib holds its last value.
REQ-024 Per channel: pointer AW bits, one-byte buffer, valid flag, half flag (0 = high nibble next).
REQ-025 Channel requests a fetch when busy & ~valid & no fetch for it pending.
REQ-026 Fetch FSM states: IDLE, SETTLE, READ.
REQ-027 IDLE: on any request, grant round-robin, starting after the last granted channel; latch rom_addr; rom_cs := 1; go to SETTLE.
REQ-028 SETTLE lasts exactly one clk and ignores rom_ok; then READ.
REQ-029 READ: on rom_ok, buffer := rom_data, valid := 1, rom_cs := 0, go to IDLE; rom_addr stays stable throughout the grant.
REQ-030 Start or stop on the granted channel during SETTLE/READ: fetch completes on the bus, data discarded, valid stays 0.
REQ-031 On cen_oki, each busy channel with valid emits a nibble: high nibble if half = 0, else low; nib_stb pulses the next clk; half toggles.
REQ-032 After the low nibble: valid := 0; if ptr == end address, busy := 0, else ptr := ptr+1 modulo 2^AW, wrapping from all-ones to 0.
REQ-033 cen_oki on a busy channel with valid = 0: no nib_stb, underrun := 1, ptr and half unchanged.
REQ-034 cen_oki on an idle channel: no action.
REQ-035 Register write coincident with cen_oki on the same channel: write wins, strobe ignored for that channel.
REQ-036 Start while busy restarts playback; half := 0.
REQ-037 Idle-bus rom_ok pulses are ignored.

Reset
REQ-038 While rstn is low: rom_cs = 0, rom_addr = 0, nib = 0, nib_stb = 0, busy = 0, underrun = 0, all pointers/pages = 0, FSM = IDLE, round-robin pointer = channel 0.
REQ-039 Reset assertion mid-fetch aborts immediately; no state survives.

Verification
REQ-040 CH=2, AW=16: ch0 start=0x12, end=0x12, start; ROM byte k = k[7:0]; rom_ok 2 clk after cs -> 512 nib_stb, first nib 0 then 0, last F,F, rom_addr 0x01200..0x012FF, busy drops after the 512th strobe.
REQ-041 Both channels started on the same cycle -> grants alternate ch0,ch1,ch0...; rom_addr[16] toggles each fetch.
REQ-042 rom_ok held low for 10 cen_oki periods after start -> underrun[0] = 1, no nib_stb; release -> playback resumes at the start address with the high nibble.
REQ-043 start page 0xFF, end page 0x00 -> ptr wraps 0xFFFF -> 0x0000 and stops after 0x00FF.
REQ-044 Stop written during READ -> rom_cs drops on rom_ok, busy = 0, no further nib_stb.
REQ-045 rstn pulsed low mid-fetch -> all outputs 0 asynchronously; a fresh start then fetches from the new start address.
